am_watchdog_timer: RTL and testbench
====================================

// Module: am_watchdog_timer
// PURPOSE
//   Software-liveness watchdog for the AM radio FPGA datapath.
//   While enabled, it counts clock cycles since the last heartbeat from the control processor.
//   It flags a warning when the count passes a threshold and asserts force_reset on timeout.
//   force_reset forces the downstream RF/audio path into a safe, muted reset state.
// PARAMETERS
//   TIMEOUT_CYCLES  125_000_000  cycles without heartbeat before trigger (1 s @125 MHz); 2..2^32-1
//   WARNING_CYCLES  100_000_000  cycles without heartbeat before warning; must be < TIMEOUT_CYCLES
// PORTS
//   clk          in   1   system clock; all logic on its rising edge
//   rstn         in   1   reset, asynchronous, active-low
//   enable       in   1   watchdog armed when 1
//   heartbeat    in   1   level-sampled kick; 1 in any cycle restarts the count
//   force_reset  out  1   registered, sticky timeout indication to the system
//   warning      out  1   registered, count has reached WARNING_CYCLES
//   triggered    out  1   registered timeout flag; force_reset is driven directly from it
// BEHAVIOUR
//   - One clock domain. Reset is asynchronous and active-low.
//   - Internal state: counter[31:0], warning, triggered.
//   - rstn=0, asynchronously: counter=0, warning=0, triggered=0, force_reset=0.
//   - Per rising clk edge, in priority order:
//     1. enable=0: counter<=0, warning<=0, triggered<=0. Disarming is the only non-reset way to clear a trigger.
//     2. triggered=1: hold all state; counter stays at TIMEOUT_CYCLES. Heartbeat is ignored.
//     3. heartbeat=1: counter<=0, warning<=0. Heartbeat beats increment when both apply.
//     4. Otherwise:
//        - If counter < TIMEOUT_CYCLES, counter<=counter+1; else counter saturates.
//        - warning<=1 when counter+1 >= WARNING_CYCLES.
//        - triggered<=1 when counter+1 == TIMEOUT_CYCLES.
//   - Timing:
//     - After a heartbeat edge (counter=0), triggered rises on the TIMEOUT_CYCLES-th following edge
//       that has enable=1 and heartbeat=0.
//     - warning rises on the WARNING_CYCLES-th such edge.
//   - force_reset == triggered; no added latency and no glitch path.
//   - warning stays 1 while triggered=1.
//   - The counter never wraps; arithmetic is 32-bit unsigned with saturation.
//   - Coming out of reset with enable=1, counting starts on the first edge after rstn deasserts.
//   - rstn or enable dropping mid-count discards all progress; re-arming starts again from 0.
//   - heartbeat asserted on the same edge that would reach TIMEOUT wins: no trigger.
//   - Elaboration must fail if WARNING_CYCLES >= TIMEOUT_CYCLES or TIMEOUT_CYCLES < 2.
//   - Formal properties, under `ifdef FORMAL with an f_past_valid guard:
//     - counter <= TIMEOUT_CYCLES.
//     - triggered implies warning.
//     - force_reset == triggered.
//     - A past enable=0 implies counter, warning and triggered are all 0.
//     - Cover: triggered, then disable/reset, then re-arm.
// TESTING (TIMEOUT_CYCLES=8, WARNING_CYCLES=4)
//   - rstn=0, enable=1 -> force_reset=0, warning=0, counter=0; all hold while rstn=0.
//   - rstn=1, enable=1, heartbeat=0 for 8 edges -> warning=1 after edge 4; triggered/force_reset=1 after edge 8;
//     both stay 1 for 20 more cycles with counter=8.
//   - Heartbeat every 6 cycles for 100 cycles -> warning may pulse, force_reset never 1, counter <= 6.
//   - After trigger, heartbeat=1 -> no change; then enable=0 one cycle -> all cleared;
//     re-arm -> trigger again 8 edges later.
//   - Count to 7, then heartbeat=1 on the 8th edge -> no trigger, counter=0, warning=0.
//   - Assert rstn=0 mid-cycle (between edges) at count 5 -> outputs clear immediately, before the next edge.

Source files
------------

// File: rtl/am_watchdog_timer.sv
// Software-liveness watchdog: counts cycles since the last heartbeat, raises a warning
// and then a sticky timeout that drives force_reset into the RF/audio path.
module am_watchdog_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd125_000_000,
    parameter int unsigned WARNING_CYCLES = 32'd100_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    input  logic heartbeat,
    output logic force_reset,
    output logic warning,
    output logic triggered
);

    localparam logic [32:0] TIMEOUT_EXT = {1'b0, 32'(TIMEOUT_CYCLES)};
    localparam logic [32:0] WARNING_EXT = {1'b0, 32'(WARNING_CYCLES)};
    localparam logic [31:0] TIMEOUT_C   = 32'(TIMEOUT_CYCLES);

    generate
        if ((WARNING_CYCLES >= TIMEOUT_CYCLES) || (TIMEOUT_CYCLES < 32'd2)) begin : g_bad_params
            $error("am_watchdog_timer: need 2 <= TIMEOUT_CYCLES and WARNING_CYCLES < TIMEOUT_CYCLES");
        end
    endgenerate

    logic [31:0] counter_r;
    logic        warning_r;
    logic        triggered_r;

    logic [32:0] count_inc_s;
    logic [31:0] count_next_s;
    logic        warn_hit_s;
    logic        trig_hit_s;

    // Next-count arithmetic, widened by one bit so counter+1 can never wrap.
    always_comb begin
        count_inc_s = {1'b0, counter_r} + 33'd1;
        if (count_inc_s <= TIMEOUT_EXT) begin
            count_next_s = count_inc_s[31:0];
        end else begin
            count_next_s = TIMEOUT_C;
        end
        warn_hit_s = (count_inc_s >= WARNING_EXT);
        trig_hit_s = (count_inc_s == TIMEOUT_EXT);
    end

    // Watchdog state: disarm clears, a trigger freezes everything, heartbeat restarts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            counter_r   <= 32'd0;
            warning_r   <= 1'b0;
            triggered_r <= 1'b0;
        end else if (!enable) begin
            counter_r   <= 32'd0;
            warning_r   <= 1'b0;
            triggered_r <= 1'b0;
        end else if (triggered_r) begin
            counter_r   <= counter_r;
            warning_r   <= warning_r;
            triggered_r <= triggered_r;
        end else if (heartbeat) begin
            counter_r   <= 32'd0;
            warning_r   <= 1'b0;
            triggered_r <= 1'b0;
        end else begin
            counter_r   <= count_next_s;
            warning_r   <= warning_r | warn_hit_s;
            triggered_r <= trig_hit_s;
        end
    end

    assign warning     = warning_r;
    assign triggered   = triggered_r;
    assign force_reset = triggered_r;

`ifdef FORMAL
    am_watchdog_timer_props #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_props (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .counter    (counter_r),
        .warning    (warning_r),
        .triggered  (triggered_r),
        .force_reset(force_reset)
    );
`endif

endmodule

`ifdef FORMAL
// Property checker bound into the watchdog for formal runs.
module am_watchdog_timer_props #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd125_000_000
) (
    input logic        clk,
    input logic        rstn,
    input logic        enable,
    input logic [31:0] counter,
    input logic        warning,
    input logic        triggered,
    input logic        force_reset
);

    logic f_past_valid_r;

    // Marks that at least one clean edge has passed since reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f_past_valid_r <= 1'b0;
        end else begin
            f_past_valid_r <= 1'b1;
        end
    end

    // Invariants checked on every edge once history is valid.
    always @(posedge clk) begin
        if (f_past_valid_r && rstn) begin
            assert (counter <= 32'(TIMEOUT_CYCLES));
            assert (!triggered || warning);
            assert (force_reset == triggered);
            if (!$past(enable) && $past(rstn)) begin
                assert ((counter == 32'd0) && !warning && !triggered);
            end
        end
    end

    cover property (@(posedge clk) disable iff (!f_past_valid_r)
        triggered ##[1:$] (!enable || !rstn) ##[1:$] (enable && rstn && (counter != 32'd0)));

endmodule
`endif

// File: tb/tb_am_watchdog_timer.sv
// Directed and randomized bench for am_watchdog_timer against a count-since-heartbeat model.
module tb_am_watchdog_timer;

    localparam int T = 8;
    localparam int W = 4;

    logic clk;
    logic rstn;
    logic enable;
    logic heartbeat;
    logic force_reset;
    logic warning;
    logic triggered;

    int errors = 0;
    int checks = 0;
    int m_cnt  = 0;

    am_watchdog_timer #(
        .TIMEOUT_CYCLES(T),
        .WARNING_CYCLES(W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .heartbeat  (heartbeat),
        .force_reset(force_reset),
        .warning    (warning),
        .triggered  (triggered)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model view: warning means at least W quiet cycles, trigger means the count reached T.
    task automatic check_all(input string tag);
        chk({tag, ".counter"},     dut.counter_r, 32'(m_cnt));
        chk({tag, ".warning"},     {31'd0, warning},     {31'd0, (m_cnt >= W)});
        chk({tag, ".triggered"},   {31'd0, triggered},   {31'd0, (m_cnt == T)});
        chk({tag, ".force_reset"}, {31'd0, force_reset}, {31'd0, (m_cnt == T)});
    endtask

    task automatic step(input logic en, input logic hb, input string tag);
        enable    = en;
        heartbeat = hb;
        @(posedge clk);
        if (!rstn || !en)   m_cnt = 0;
        else if (m_cnt == T) m_cnt = m_cnt;
        else if (hb)         m_cnt = 0;
        else                 m_cnt = m_cnt + 1;
        #1;
        check_all(tag);
    endtask

    initial begin
        rstn      = 1'b0;
        enable    = 1'b1;
        heartbeat = 1'b0;
        #1;
        check_all("reset_async");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "reset_hold");

        rstn = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "count_to_trigger");
        chk("trigger_after_8", {31'd0, force_reset}, 32'd1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, "trigger_sticky");

        step(1'b1, 1'b1, "hb_ignored_when_triggered");
        chk("hb_ignored_counter", dut.counter_r, 32'd8);
        step(1'b0, 1'b0, "disarm_clears");
        chk("disarm_force_reset", {31'd0, force_reset}, 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "rearm_trigger");
        chk("rearm_triggered", {31'd0, triggered}, 32'd1);

        step(1'b0, 1'b0, "disarm2");
        for (int i = 0; i < 100; i++) begin
            step(1'b1, (i % 6) == 5, "hb_every_6");
            chk("hb6_no_force", {31'd0, force_reset}, 32'd0);
            chk("hb6_counter_le6", {31'd0, (dut.counter_r <= 32'd6)}, 32'd1);
        end

        step(1'b0, 1'b0, "disarm3");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, "count_to_7");
        step(1'b1, 1'b1, "hb_on_8th_edge");
        chk("hb_wins_no_trigger", {31'd0, triggered}, 32'd0);
        chk("hb_wins_counter", dut.counter_r, 32'd0);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "count_to_5");
        #2;
        rstn = 1'b0;
        m_cnt = 0;
        #1;
        check_all("midcycle_reset");
        #3;
        rstn = 1'b1;
        step(1'b1, 1'b0, "after_midcycle_reset");

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 11) == 0), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
